// File: rtl/axis_lag_diff_pkg.sv
// Shared helpers for the lag differentiator.
// Lag register width and difference width are derived here so that the top and
// any future users agree on sizing.
package axis_lag_diff_pkg;

    // Width needed to hold a lag value in 0..max_lag
    function automatic int lag_width(input int max_lag);
        return $clog2(max_lag + 1);
    endfunction

    // Width of a full-precision difference of two signed samples
    function automatic int diff_width(input int sample_width);
        return sample_width + 1;
    endfunction

endpackage

// File: rtl/axis_lag_differentiator_sample_history.sv
// sample_history: MAX_LAG-deep sample shift register.
// Advances PARALLEL_SAMPLES per accepted beat and exposes {current beat, history}
// with sample 0 (oldest) in the lowest bits.
// i_clear masks the stored history to zero. When i_clear is asserted together with
// i_shift, the masked view is the one that is shifted in.
module sample_history #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int PARALLEL_SAMPLES = 2,
    parameter int DEPTH            = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              i_shift,
    input  logic                                              i_clear,
    input  logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0]          i_beat,
    output logic [SAMPLE_WIDTH*(DEPTH+PARALLEL_SAMPLES)-1:0]  o_full
);

    localparam int HW = SAMPLE_WIDTH * DEPTH;
    localparam int FW = HW + SAMPLE_WIDTH * PARALLEL_SAMPLES;

    logic [HW-1:0] r_hist;
    logic [HW-1:0] w_hist_view;

    // History as seen by the lag muxes: zero on the transfer that applies a new lag
    always_comb begin
        w_hist_view = r_hist;
        if (i_clear) begin
            w_hist_view = '0;
        end else begin
            w_hist_view = r_hist;
        end
    end

    assign o_full = {i_beat, w_hist_view};

    // Keep the newest DEPTH samples of {beat, history} on every accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist <= o_full[FW-1 -: HW];
        end else if (i_clear) begin
            r_hist <= '0;
        end else begin
            r_hist <= r_hist;
        end
    end

endmodule

// File: rtl/axis_lag_differentiator.sv
// axis_lag_differentiator: y[n] = (x[n] - x[n-K]) / 2 on signed AXI-stream samples,
// with K selectable at runtime in the range 1..MAX_LAG.
// The AXI-stream bundles are flattened as <bundle>_<field>.
// The two-stage pipeline stalls as a single unit.
// Optional build macro AXIS_LAG_DIFF_SATURATE_EN: output the saturated full-gain
// difference instead of the halved difference.
module axis_lag_differentiator
    import axis_lag_diff_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int PARALLEL_SAMPLES = 2,
    parameter int MAX_LAG          = 8,
    localparam int LAG_W           = lag_width(MAX_LAG),
    localparam int W               = SAMPLE_WIDTH * PARALLEL_SAMPLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [W-1:0]     data_in_data,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    input  logic             data_in_last,
    output logic [W-1:0]     data_out_data,
    output logic             data_out_valid,
    input  logic             data_out_ready,
    output logic             data_out_last,
    input  logic [LAG_W-1:0] lag_config_data,
    input  logic             lag_config_valid,
    output logic             lag_config_ready
);

    localparam int SW = SAMPLE_WIDTH;
    localparam int P  = PARALLEL_SAMPLES;
    localparam int DW = diff_width(SAMPLE_WIDTH);
    localparam int NF = MAX_LAG + PARALLEL_SAMPLES;

    typedef logic signed [SW-1:0] sample_t;

    logic [LAG_W-1:0] r_lag;
    logic [LAG_W-1:0] r_lag_new;
    logic             r_lag_pend;

    logic             r_s1_valid;
    logic             r_s1_last;
    sample_t          r_s1_x  [P];
    sample_t          r_s1_xk [P];

    logic             r_s2_valid;
    logic             r_s2_last;
    logic [W-1:0]     r_s2_data;

    logic             w_s2_free;
    logic             w_in_fire;
    logic             w_cfg_ok;
    logic             w_clear;
    logic [LAG_W-1:0] w_lag_eff;
    logic [SW*NF-1:0] w_full_flat;
    sample_t          w_full_arr [NF];
    sample_t          w_xk [P];
    logic signed [DW-1:0] w_d [P];
    logic [W-1:0]     w_y;

    assign w_s2_free        = !r_s2_valid || data_out_ready;
    assign data_in_ready    = w_s2_free;
    assign w_in_fire        = data_in_valid && w_s2_free;
    assign w_cfg_ok         = lag_config_valid && (lag_config_data != {LAG_W{1'b0}})
                              && (lag_config_data <= LAG_W'(MAX_LAG));
    assign w_lag_eff        = r_lag_pend ? r_lag_new : r_lag;
    assign w_clear          = w_in_fire && r_lag_pend;
    assign lag_config_ready = 1'b1;

    sample_history #(
        .SAMPLE_WIDTH     (SW),
        .PARALLEL_SAMPLES (P),
        .DEPTH            (MAX_LAG)
    ) u_history (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_shift (w_in_fire),
        .i_clear (w_clear),
        .i_beat  (data_in_data),
        .o_full  (w_full_flat)
    );

    for (genvar j = 0; j < NF; j++) begin : g_unpack
        assign w_full_arr[j] = w_full_flat[j*SW +: SW];
    end

    // Lag latch: a legal config waits for the next input transfer, which then uses it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lag      <= LAG_W'(1);
            r_lag_new  <= LAG_W'(1);
            r_lag_pend <= 1'b0;
        end else begin
            r_lag <= w_clear ? r_lag_new : r_lag;
            if (w_cfg_ok) begin
                r_lag_new  <= lag_config_data;
                r_lag_pend <= 1'b1;
            end else if (w_in_fire) begin
                r_lag_new  <= r_lag_new;
                r_lag_pend <= 1'b0;
            end else begin
                r_lag_new  <= r_lag_new;
                r_lag_pend <= r_lag_pend;
            end
        end
    end

    // Lag select muxes: pick x[n-K] for each sample from {history, current beat}
    always_comb begin
        for (int i = 0; i < P; i++) begin
            w_xk[i] = '0;
            for (int k = 1; k <= MAX_LAG; k++) begin
                if (w_lag_eff == LAG_W'(k)) begin
                    w_xk[i] = w_full_arr[MAX_LAG + i - k];
                end else begin
                    w_xk[i] = w_xk[i];
                end
            end
        end
    end

    // Stage 1: register x[n] and the selected x[n-K] when the pipe can advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            for (int i = 0; i < P; i++) begin
                r_s1_x[i]  <= '0;
                r_s1_xk[i] <= '0;
            end
        end else if (w_s2_free) begin
            r_s1_valid <= data_in_valid;
            r_s1_last  <= data_in_last;
            for (int i = 0; i < P; i++) begin
                r_s1_x[i]  <= w_full_arr[MAX_LAG + i];
                r_s1_xk[i] <= w_xk[i];
            end
        end else begin
            r_s1_valid <= r_s1_valid;
            r_s1_last  <= r_s1_last;
            for (int i = 0; i < P; i++) begin
                r_s1_x[i]  <= r_s1_x[i];
                r_s1_xk[i] <= r_s1_xk[i];
            end
        end
    end

    // Stage 2 arithmetic: full-precision difference, then halve (floor) or saturate
    always_comb begin
        w_y = '0;
        for (int i = 0; i < P; i++) begin
            w_d[i] = DW'(r_s1_x[i]) - DW'(r_s1_xk[i]);
`ifdef AXIS_LAG_DIFF_SATURATE_EN
            if (w_d[i][DW-1] != w_d[i][DW-2]) begin
                w_y[i*SW +: SW] = w_d[i][DW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
            end else begin
                w_y[i*SW +: SW] = w_d[i][SW-1:0];
            end
`else
            w_y[i*SW +: SW] = w_d[i][DW-1:1];
`endif
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s2_free && r_s1_valid) begin
            r_s2_valid <= 1'b1;
            r_s2_last  <= r_s1_last;
            r_s2_data  <= w_y;
        end else if (w_s2_free) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= r_s2_last;
            r_s2_data  <= r_s2_data;
        end else begin
            r_s2_valid <= r_s2_valid;
            r_s2_last  <= r_s2_last;
            r_s2_data  <= r_s2_data;
        end
    end

    assign data_out_valid = r_s2_valid;
    assign data_out_last  = r_s2_last;
    assign data_out_data  = r_s2_data;

endmodule

// File: tb/tb_axis_lag_differentiator.sv
// Self-checking bench for axis_lag_differentiator: directed cases plus randomized
// valid/ready traffic checked against a queue-based reference model.
module tb_axis_lag_differentiator;
    import axis_lag_diff_pkg::*;

    localparam int SW = 16;
    localparam int P  = 2;
    localparam int ML = 8;
    localparam int LW = lag_width(ML);
    localparam int W  = SW * P;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  data_in_data = '0;
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic          data_in_last = 1'b0;
    logic [W-1:0]  data_out_data;
    logic          data_out_valid;
    logic          data_out_ready = 1'b0;
    logic          data_out_last;
    logic [LW-1:0] lag_config_data = '0;
    logic          lag_config_valid = 1'b0;
    logic          lag_config_ready;

    axis_lag_differentiator #(
        .SAMPLE_WIDTH     (SW),
        .PARALLEL_SAMPLES (P),
        .MAX_LAG          (ML)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .data_in_data     (data_in_data),
        .data_in_valid    (data_in_valid),
        .data_in_ready    (data_in_ready),
        .data_in_last     (data_in_last),
        .data_out_data    (data_out_data),
        .data_out_valid   (data_out_valid),
        .data_out_ready   (data_out_ready),
        .data_out_last    (data_out_last),
        .lag_config_data  (lag_config_data),
        .lag_config_valid (lag_config_valid),
        .lag_config_ready (lag_config_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int           m_hist[$];
    int           m_exp_s[$];
    bit           m_exp_l[$];
    int           m_lag  = 1;
    int           m_new  = 1;
    bit           m_pend = 1'b0;
    int           n_in   = 0;
    int           n_out  = 0;
    logic [W-1:0] out_log[$];
    bit           h_valid = 1'b0;
    logic [W-1:0] h_data;
    logic         h_last;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sx(input logic [W-1:0] d, input int i);
        logic signed [SW-1:0] t;
        t = d[i*SW +: SW];
        return int'(t);
    endfunction

    function automatic logic [W-1:0] pack2(input int a, input int b);
        logic [W-1:0] r;
        r[SW-1:0]  = a[SW-1:0];
        r[W-1:SW]  = b[SW-1:0];
        return r;
    endfunction

    function automatic int ref_y(input int x, input int xk);
        int d;
        d = x - xk;
`ifdef AXIS_LAG_DIFF_SATURATE_EN
        if (d > 32767) return 32767;
        if (d < -32768) return -32768;
        return d;
`else
        return (d >= 0) ? d / 2 : -((-d + 1) / 2);
`endif
    endfunction

    task automatic model_accept(input logic [W-1:0] d, input logic l);
        int keff;
        int base;
        int idx;
        int xk;
        keff = m_pend ? m_new : m_lag;
        if (m_pend) begin
            m_hist.delete();
            m_lag  = m_new;
            m_pend = 1'b0;
        end
        base = m_hist.size();
        for (int i = 0; i < P; i++) m_hist.push_back(sx(d, i));
        for (int i = 0; i < P; i++) begin
            idx = base + i;
            xk  = (idx - keff >= 0) ? m_hist[idx - keff] : 0;
            m_exp_s.push_back(ref_y(m_hist[idx], xk));
        end
        m_exp_l.push_back(l);
        while (m_hist.size() > ML) void'(m_hist.pop_front());
    endtask

    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic l, input logic ordy,
                       input logic cv, input logic [LW-1:0] cd);
        bit in_fire;
        bit out_fire;
        @(negedge clk);
        data_in_valid    = iv;
        data_in_data     = d;
        data_in_last     = l;
        data_out_ready   = ordy;
        lag_config_valid = cv;
        lag_config_data  = cd;
        #1;
        if (h_valid) begin
            check("hold_valid", longint'(data_out_valid), 1);
            check("hold_data", longint'(data_out_data), longint'(h_data));
            check("hold_last", longint'(data_out_last), longint'(h_last));
        end
        in_fire  = iv && data_in_ready;
        out_fire = data_out_valid && ordy;
        if (out_fire) begin
            n_out++;
            check("out_expected", longint'(m_exp_l.size() > 0), 1);
            if (m_exp_l.size() > 0) begin
                for (int i = 0; i < P; i++)
                    check("data", longint'(sx(data_out_data, i)), longint'(m_exp_s.pop_front()));
                check("last", longint'(data_out_last), longint'(m_exp_l.pop_front()));
            end
            out_log.push_back(data_out_data);
        end
        if (in_fire) begin
            n_in++;
            model_accept(d, l);
        end
        if (cv && cd != '0 && int'(cd) <= ML) begin
            m_new  = int'(cd);
            m_pend = 1'b1;
        end
        h_valid = data_out_valid && !ordy;
        h_data  = data_out_data;
        h_last  = data_out_last;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n          = 1'b0;
        data_in_valid    = 1'b0;
        data_out_ready   = 1'b0;
        lag_config_valid = 1'b0;
        #1;
        check("rst_valid", longint'(data_out_valid), 0);
        check("rst_data", longint'(data_out_data), 0);
        check("rst_last", longint'(data_out_last), 0);
        m_hist.delete();
        m_exp_s.delete();
        m_exp_l.delete();
        out_log.delete();
        m_lag   = 1;
        m_new   = 1;
        m_pend  = 1'b0;
        n_in    = 0;
        n_out   = 0;
        h_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain();
        repeat (6) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        check("drain_empty", longint'(m_exp_l.size()), 0);
        check("drain_count", longint'(n_out), longint'(n_in));
    endtask

    task automatic chk_log(input string tag, input int n, input int a, input int b);
        check({tag, "_present"}, longint'(out_log.size() > n), 1);
        if (out_log.size() > n) begin
            check({tag, "_s0"}, longint'(sx(out_log[n], 0)), longint'(a));
            check({tag, "_s1"}, longint'(sx(out_log[n], 1)), longint'(b));
        end
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         rv;
        logic         rr;
        logic         rc;
        logic [LW-1:0] rk;
        int           ks[3];

        // reset state
        do_reset();
        #1;
        check("rst_in_ready", longint'(data_in_ready), 1);
        check("cfg_ready", longint'(lag_config_ready), 1);

        // K=1 basic
        cyc(1'b1, pack2(100, 300), 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, pack2(200, -100), 1'b1, 1'b1, 1'b0, '0);
        drain();
`ifdef AXIS_LAG_DIFF_SATURATE_EN
        chk_log("k1_b0", 0, 100, 200);
        chk_log("k1_b1", 1, -100, -300);
`else
        chk_log("k1_b0", 0, 50, 100);
        chk_log("k1_b1", 1, -50, -150);
`endif

        // K=3 with zero history
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, LW'(3));
        cyc(1'b1, pack2(1, 2), 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, pack2(3, 4), 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, pack2(5, 6), 1'b1, 1'b1, 1'b0, '0);
        drain();
`ifdef AXIS_LAG_DIFF_SATURATE_EN
        chk_log("k3_b0", 0, 1, 2);
        chk_log("k3_b1", 1, 3, 3);
        chk_log("k3_b2", 2, 3, 3);
`else
        chk_log("k3_b0", 0, 0, 1);
        chk_log("k3_b1", 1, 1, 1);
        chk_log("k3_b2", 2, 1, 1);
`endif

        // extremes with K=1
        do_reset();
        cyc(1'b1, pack2(-32768, 32767), 1'b0, 1'b1, 1'b0, '0);
        drain();
`ifdef AXIS_LAG_DIFF_SATURATE_EN
        chk_log("ext", 0, -32768, 32767);
`else
        chk_log("ext", 0, -16384, 32767);
`endif

        // lag change mid-stream, then illegal configs ignored
        do_reset();
        for (int b = 0; b < 4; b++)
            cyc(1'b1, pack2(10 + 40 * b, 30 + 40 * b), 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, LW'(2));
        cyc(1'b1, pack2(100, 200), 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, LW'(0));
        cyc(1'b1, pack2(300, 500), 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, LW'(ML + 1));
        cyc(1'b1, pack2(700, 1100), 1'b1, 1'b1, 1'b0, '0);
        drain();
`ifdef AXIS_LAG_DIFF_SATURATE_EN
        chk_log("lagchg_b4", 4, 100, 200);
        chk_log("lagchg_b5", 5, 200, 300);
        chk_log("lagchg_b6", 6, 400, 600);
`else
        chk_log("lagchg_b4", 4, 50, 100);
        chk_log("lagchg_b5", 5, 100, 150);
        chk_log("lagchg_b6", 6, 200, 300);
`endif

        // backpressure with the pipe full
        do_reset();
        cyc(1'b1, pack2(1000, -2000), 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, pack2(3000, 4000), 1'b1, 1'b0, 1'b0, '0);
        repeat (5) begin
            cyc(1'b1, pack2(5, 7), 1'b0, 1'b0, 1'b0, '0);
            check("bp_in_ready", longint'(data_in_ready), 0);
        end
        cyc(1'b1, pack2(5, 7), 1'b0, 1'b1, 1'b0, '0);
        drain();

        // reset mid-stream
        cyc(1'b1, pack2(111, 222), 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, pack2(333, 444), 1'b0, 1'b0, 1'b0, '0);
        do_reset();
        cyc(1'b1, pack2(40, 80), 1'b0, 1'b1, 1'b0, '0);
        drain();
`ifdef AXIS_LAG_DIFF_SATURATE_EN
        chk_log("post_rst", 0, 40, 40);
`else
        chk_log("post_rst", 0, 20, 20);
`endif

        // randomized traffic for K in {1, P, MAX_LAG}
        ks[0] = 1;
        ks[1] = P;
        ks[2] = ML;
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, LW'(ks[s]));
            for (int c = 0; c < 650; c++) begin
                rd = $urandom;
                rv = ($urandom_range(3) != 0);
                rr = ($urandom_range(2) != 0);
                rc = ($urandom_range(31) == 0);
                rk = ($urandom_range(1) == 0) ? LW'(0) : LW'($urandom_range(15, ML + 1));
                cyc(rv, rd, rd[0], rr, rc, rk);
            end
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
